// File: rtl/ddr_arb_pkg.sv
// Shared constants for the DDR burst arbiter: default geometry, index width, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_arb_pkg;

  localparam int DEF_FRAME_WORDS = 115200;
  localparam int DEF_BURST_LEN   = 8;
  localparam int IDX_W           = 27;

  // 3-bit state encoding kept as plain constants so older netlists and probes stay compatible.
  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_WR_CMD  = 3'd1;
  localparam arb_state_t ST_WR_DATA = 3'd2;
  localparam arb_state_t ST_RD_CMD  = 3'd3;
  localparam arb_state_t ST_RD_DATA = 3'd4;

endpackage

// File: rtl/ddr_burst_arbiter_if.sv
// Bundle of request, command and beat handshakes between the arbiter and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: every data path is a valid/ready pair; commands stall on cmd_ready.
interface ddr_burst_arbiter_if;
  import ddr_arb_pkg::*;

  logic             wr_req;
  logic             rd_req;
  logic             wr_src_valid;
  logic             wr_src_ready;
  logic             rd_dst_valid;
  logic             rd_dst_ready;
  logic             cmd_valid;
  logic             cmd_write;
  logic [IDX_W-1:0] cmd_addr;
  logic             cmd_ready;
  logic             mem_wvalid;
  logic             mem_wlast;
  logic             mem_wready;
  logic             mem_rvalid;
  logic             mem_rready;
  logic             wr_frame_done;
  logic             rd_frame_done;

  // Arbiter side.
  modport master (
    input  wr_req, rd_req, wr_src_valid, rd_dst_ready, cmd_ready, mem_wready, mem_rvalid,
    output wr_src_ready, rd_dst_valid, cmd_valid, cmd_write, cmd_addr,
           mem_wvalid, mem_wlast, mem_rready, wr_frame_done, rd_frame_done
  );

  // Requester / memory side.
  modport slave (
    output wr_req, rd_req, wr_src_valid, rd_dst_ready, cmd_ready, mem_wready, mem_rvalid,
    input  wr_src_ready, rd_dst_valid, cmd_valid, cmd_write, cmd_addr,
           mem_wvalid, mem_wlast, mem_rready, wr_frame_done, rd_frame_done
  );

endinterface

// File: rtl/burst_addr_counter.sv
// Frame word index that steps by one burst and wraps to zero at the frame size.
// Latency: index updates the cycle after advance; wrap is combinational with advance.
// Backpressure: none; advances only when told.
module burst_addr_counter
  import ddr_arb_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int BURST_LEN   = DEF_BURST_LEN
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             advance,
  output logic [IDX_W-1:0] index,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] STEP  = IDX_W'(BURST_LEN);
  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(FRAME_WORDS);

  logic [IDX_W-1:0] next_index;

  assign next_index = index + STEP;
  // Pulse in the same cycle as the advancing beat so the frame boundary lines up with the last word.
  assign wrap       = advance && (next_index >= LIMIT);

  // Step by one burst, folding back to zero when the frame is exhausted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      index <= '0;
    end else if (advance) begin
      index <= (next_index >= LIMIT) ? '0 : next_index;
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Time-shares one DDR port between a frame writer and a frame reader, one fixed burst at a time.
// Latency: one IDLE cycle, command held until cmd_ready, then BURST_LEN handshaked beats.
// Backpressure: command waits on cmd_ready; beats pass valid/ready straight through both ways.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int BURST_LEN   = DEF_BURST_LEN
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  ddr_burst_arbiter_if.master  bus
);

  localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_was_write;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             in_wr_data;
  logic             in_rd_data;
  logic             cmd_acc;
  logic             wr_beat;
  logic             rd_beat;
  logic             wr_final;
  logic             rd_final;
  logic             wr_wrap;
  logic             rd_wrap;

  assign in_wr_data = (state == ST_WR_DATA);
  assign in_rd_data = (state == ST_RD_DATA);

  // Command is a pure function of state and registered indices, so it cannot glitch while stalled.
  assign bus.cmd_valid = (state == ST_WR_CMD) || (state == ST_RD_CMD);
  assign bus.cmd_write = (state == ST_WR_CMD);
  assign bus.cmd_addr  = (state == ST_WR_CMD) ? (wr_idx << 4) : (rd_idx << 4);
  assign cmd_acc       = bus.cmd_valid && bus.cmd_ready;

  // Data paths are combinational pass-throughs, gated so nothing leaks outside the owning state.
  assign bus.mem_wvalid   = in_wr_data && bus.wr_src_valid;
  assign bus.wr_src_ready = in_wr_data && bus.mem_wready;
  assign bus.mem_wlast    = in_wr_data && (beat_cnt == LAST_BEAT);
  assign bus.rd_dst_valid = in_rd_data && bus.mem_rvalid;
  assign bus.mem_rready   = in_rd_data && bus.rd_dst_ready;

  assign wr_beat  = bus.mem_wvalid && bus.mem_wready;
  assign rd_beat  = bus.mem_rvalid && bus.mem_rready;
  assign wr_final = wr_beat && (beat_cnt == LAST_BEAT);
  assign rd_final = rd_beat && (beat_cnt == LAST_BEAT);

  assign bus.wr_frame_done = wr_wrap;
  assign bus.rd_frame_done = rd_wrap;

  // Next-state: on a tie, serve whichever direction did not go last.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.wr_req && bus.rd_req) state_nxt = last_was_write ? ST_RD_CMD : ST_WR_CMD;
        else if (bus.wr_req)          state_nxt = ST_WR_CMD;
        else if (bus.rd_req)          state_nxt = ST_RD_CMD;
      end
      ST_WR_CMD:  if (bus.cmd_ready) state_nxt = ST_WR_DATA;
      ST_WR_DATA: if (wr_final)      state_nxt = ST_IDLE;
      ST_RD_CMD:  if (bus.cmd_ready) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (rd_final)      state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // State, beat count and fairness flag; requests are ignored once a burst is granted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      last_was_write <= 1'b1;
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        beat_cnt <= '0;
      end else if (wr_beat || rd_beat) begin
        beat_cnt <= (wr_final || rd_final) ? '0 : beat_cnt + CNT_W'(1);
      end
      if (wr_final)      last_was_write <= 1'b1;
      else if (rd_final) last_was_write <= 1'b0;
    end
  end

  burst_addr_counter #(
    .FRAME_WORDS (FRAME_WORDS),
    .BURST_LEN   (BURST_LEN)
  ) u_wr_addr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .advance (wr_final),
    .index   (wr_idx),
    .wrap    (wr_wrap)
  );

  burst_addr_counter #(
    .FRAME_WORDS (FRAME_WORDS),
    .BURST_LEN   (BURST_LEN)
  ) u_rd_addr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .advance (rd_final),
    .index   (rd_idx),
    .wrap    (rd_wrap)
  );

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench for ddr_burst_arbiter: a burst-level model predicts every command, the monitor
// checks commands, beat pass-through, wlast, frame-done pulses and the IDLE gap between bursts.
// A small frame size is used so wrap-around is reached in a short run.
`timescale 1ns/1ps
module tb_ddr_burst_arbiter;
  import ddr_arb_pkg::*;

  localparam int FW = 64;
  localparam int BL = 8;

  localparam int M_IDLE = 0;
  localparam int M_CMDW = 1;
  localparam int M_WD   = 2;
  localparam int M_RD   = 3;
  localparam int M_GAP  = 4;

  typedef struct packed {
    logic             write;
    logic [IDX_W-1:0] addr;
    logic             wrap;
  } exp_t;

  logic clk;
  logic rst;

  ddr_burst_arbiter_if bus();

  ddr_burst_arbiter #(
    .FRAME_WORDS (FW),
    .BURST_LEN   (BL)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Burst-level reference state.
  int   m_wr_idx;
  int   m_rd_idx;
  logic m_last_w;

  // Driver configuration.
  int   mode = 0;
  int   stall_seen = 0;
  logic tog = 1'b0;

  // Monitor state.
  int   mph = M_IDLE;
  int   mbeats = 0;
  int   bursts_done = 0;
  exp_t cur;
  logic [IDX_W:0] held;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_wr_idx = 0;
    m_rd_idx = 0;
    m_last_w = 1'b1;
    exp_q.delete();
  endtask

  // Each granted burst: pick direction, emit its command address, move that frame pointer.
  task automatic model_push(input logic wr, input logic rd, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic w;
      w = (wr && rd) ? !m_last_w : wr;
      m_last_w = w;
      e.write = w;
      if (w) begin
        e.addr   = IDX_W'(m_wr_idx * 16);
        e.wrap   = (m_wr_idx + BL) == FW;
        m_wr_idx = (m_wr_idx + BL) % FW;
      end else begin
        e.addr   = IDX_W'(m_rd_idx * 16);
        e.wrap   = (m_rd_idx + BL) == FW;
        m_rd_idx = (m_rd_idx + BL) % FW;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run_phase(input logic wr, input logic rd, input int n, input int md);
    int target;
    int waited;
    model_push(wr, rd, n);
    target     = bursts_done + n;
    stall_seen = 0;
    mode       = md;
    bus.wr_req = wr;
    bus.rd_req = rd;
    waited     = 0;
    while (bursts_done < target && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bursts_done < target) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout: bursts done %0d required %0d", bursts_done, target);
      exp_q.delete();
    end
  endtask

  // Handshake driver: inputs change 1ns after the rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (mode)
        1: begin
          bus.cmd_ready    = ($urandom_range(0, 9) < 7);
          bus.wr_src_valid = ($urandom_range(0, 9) < 7);
          bus.mem_wready   = ($urandom_range(0, 9) < 7);
          bus.mem_rvalid   = ($urandom_range(0, 9) < 7);
          bus.rd_dst_ready = ($urandom_range(0, 9) < 7);
        end
        2: begin
          bus.cmd_ready    = (stall_seen >= 5);
          if (bus.cmd_valid && stall_seen < 5) stall_seen++;
          bus.wr_src_valid = 1'b1;
          bus.mem_wready   = 1'b1;
          bus.mem_rvalid   = 1'b1;
          bus.rd_dst_ready = 1'b1;
        end
        3: begin
          tog              = ~tog;
          bus.cmd_ready    = 1'b1;
          bus.wr_src_valid = 1'b1;
          bus.mem_wready   = 1'b1;
          bus.mem_rvalid   = 1'b1;
          bus.rd_dst_ready = tog;
        end
        default: begin
          bus.cmd_ready    = 1'b1;
          bus.wr_src_valid = 1'b1;
          bus.mem_wready   = 1'b1;
          bus.mem_rvalid   = 1'b1;
          bus.rd_dst_ready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops expectations on command acceptance.
  initial begin
    logic beat;
    logic fin;
    forever begin
      @(negedge clk);
      if (rst) begin
        mph    = M_IDLE;
        mbeats = 0;
      end else begin
        case (mph)
          M_WD: begin
            chk("wr_pass_valid", 32'(bus.mem_wvalid), 32'(bus.wr_src_valid));
            chk("wr_pass_ready", 32'(bus.wr_src_ready), 32'(bus.mem_wready));
            chk("wlast", 32'(bus.mem_wlast), 32'(mbeats == BL - 1));
            chk("rd_path_in_wr", 32'({bus.rd_dst_valid, bus.mem_rready}), 32'd0);
            chk("cmd_in_wr_data", 32'(bus.cmd_valid), 32'd0);
            beat = bus.wr_src_valid && bus.mem_wready;
            fin  = beat && (mbeats == BL - 1);
            chk("wr_frame_done", 32'(bus.wr_frame_done), 32'(fin && cur.wrap));
            chk("rd_frame_done_in_wr", 32'(bus.rd_frame_done), 32'd0);
            if (fin) begin
              mph    = M_GAP;
              mbeats = 0;
              bursts_done++;
            end else if (beat) begin
              mbeats++;
            end
          end
          M_RD: begin
            chk("rd_pass_valid", 32'(bus.rd_dst_valid), 32'(bus.mem_rvalid));
            chk("rd_pass_ready", 32'(bus.mem_rready), 32'(bus.rd_dst_ready));
            chk("wr_path_in_rd", 32'({bus.mem_wvalid, bus.wr_src_ready, bus.mem_wlast}), 32'd0);
            chk("cmd_in_rd_data", 32'(bus.cmd_valid), 32'd0);
            beat = bus.mem_rvalid && bus.rd_dst_ready;
            fin  = beat && (mbeats == BL - 1);
            chk("rd_frame_done", 32'(bus.rd_frame_done), 32'(fin && cur.wrap));
            chk("wr_frame_done_in_rd", 32'(bus.wr_frame_done), 32'd0);
            if (fin) begin
              mph    = M_GAP;
              mbeats = 0;
              bursts_done++;
            end else if (beat) begin
              mbeats++;
            end
          end
          default: begin
            chk("wr_path_quiet", 32'({bus.mem_wvalid, bus.wr_src_ready, bus.mem_wlast}), 32'd0);
            chk("rd_path_quiet", 32'({bus.rd_dst_valid, bus.mem_rready}), 32'd0);
            chk("frame_done_quiet", 32'({bus.wr_frame_done, bus.rd_frame_done}), 32'd0);
            if (mph == M_GAP) begin
              chk("idle_gap_cmd_valid", 32'(bus.cmd_valid), 32'd0);
              mph = M_IDLE;
            end else if (mph == M_CMDW) begin
              chk("cmd_hold_valid", 32'(bus.cmd_valid), 32'd1);
              chk("cmd_hold_fields", 32'({bus.cmd_write, bus.cmd_addr}), 32'(held));
              if (!bus.cmd_valid) begin
                mph = M_IDLE;
              end else if (bus.cmd_ready) begin
                mph    = bus.cmd_write ? M_WD : M_RD;
                mbeats = 0;
              end
            end else if (bus.cmd_valid) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got write=%0d addr=%0d want no command",
                         bus.cmd_write, bus.cmd_addr);
                cur = '{write: bus.cmd_write, addr: bus.cmd_addr, wrap: 1'b0};
              end else begin
                cur = exp_q.pop_front();
                chk("cmd_write", 32'(bus.cmd_write), 32'(cur.write));
                chk("cmd_addr", 32'(bus.cmd_addr), 32'(cur.addr));
              end
              held = {bus.cmd_write, bus.cmd_addr};
              if (bus.cmd_ready) begin
                mph    = bus.cmd_write ? M_WD : M_RD;
                mbeats = 0;
              end else begin
                mph = M_CMDW;
              end
            end
          end
        endcase
      end
    end
  end

  // Stimulus: reset, directed phases, random phases, then a reset in the middle of a write.
  initial begin
    int waited;
    rst              = 1'b1;
    bus.wr_req       = 1'b0;
    bus.rd_req       = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.wr_src_valid = 1'b0;
    bus.mem_wready   = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.rd_dst_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_mem_wvalid", 32'(bus.mem_wvalid), 32'd0);
    chk("rst_wr_src_ready", 32'(bus.wr_src_ready), 32'd0);
    chk("rst_rd_dst_valid", 32'(bus.rd_dst_valid), 32'd0);
    chk("rst_mem_rready", 32'(bus.mem_rready), 32'd0);
    chk("rst_frame_done", 32'({bus.wr_frame_done, bus.rd_frame_done}), 32'd0);

    run_phase(1'b1, 1'b0, 2, 0);   // writes only: addresses 0 then 0x80
    run_phase(1'b1, 1'b1, 4, 0);   // contention: R,W,R,W
    run_phase(1'b0, 1'b1, 1, 2);   // command held off for 5 cycles
    run_phase(1'b0, 1'b1, 2, 3);   // sink ready toggling during reads
    run_phase(1'b1, 1'b0, 8, 1);   // write pointer crosses the frame end
    run_phase(1'b1, 1'b1, 20, 1);  // random handshakes under contention

    // Write burst cut by reset while its 4th beat is on the bus.
    model_push(1'b1, 1'b0, 1);
    mode       = 0;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b0;
    waited     = 0;
    while (!(mph == M_WD && mbeats == 3) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      errors++;
      $display("FAIL reset_setup_timeout: beats %0d required 3", mbeats);
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_wvalid", 32'(bus.mem_wvalid), 32'd0);
    chk("mid_rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    run_phase(1'b1, 1'b0, 1, 0);   // restarts at word 0

    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
